usb_in_ep_arbiter: RTL and testbench
====================================

Name: usb_in_ep_arbiter

Overview:
- Round-robin arbiter that shares the single USB IN packet buffer between NUM_EP IN endpoint clients (control EP0, CDC ACM notify, CDC TX).
- Each client uses the same req/grant/data_free/data_put/data/data_done interface the control endpoint already drives.
- Holds a grant for a whole packet, multiplexes the granted client onto the buffer write port, and flags protocol violations.

Parameters:
- NUM_EP, 3, number of IN endpoint clients (legal range 2..8); index 0 is EP0.
- MAX_PKT, 32, maximum packet length in bytes (legal range 1..64).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- ep_req  input  NUM_EP  per-client request, level.
- ep_grant  output  NUM_EP  per-client grant, one-hot or zero, registered.
- ep_data_free  output  NUM_EP  buf_free routed to the granted client, 0 to all others.
- ep_data_put  input  NUM_EP  per-client byte strobe.
- ep_data  input  8*NUM_EP  per-client byte; client i uses bits [8i+7:8i].
- ep_data_done  input  NUM_EP  per-client end-of-packet pulse.
- buf_free  input  1  shared buffer can accept a byte this cycle.
- buf_put  output  1  byte write to the shared buffer.
- buf_data  output  8  byte to the shared buffer.
- buf_done  output  1  packet commit to the shared buffer.
- grant_idx  output  3  index of the current or last granted client, registered.
- busy  output  1  high while any grant is held.
- pkt_len  output  7  bytes written in the current packet, registered.
- proto_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, reset_n low):
  - ep_grant=0, busy=0, grant_idx=NUM_EP-1, pkt_len=0, proto_err=0, state=IDLE.
  - The round-robin pointer is set so client 0 has first priority after reset.
  - Reset asserted mid-packet drops the grant immediately. No buf_done is issued; the buffer owner discards the partial packet.
- State ARB:
  - If any ep_req is high, select the first requester searching from grant_idx+1 with wrap modulo NUM_EP.
  - At the next edge: set ep_grant[sel]=1, grant_idx=sel, busy=1, pkt_len=0, state=HOLD.
  - Grant latency is one cycle from req sampled high to grant high.
  - If no requester, stay in ARB.
- State HOLD (granted index g):
  - Combinational routing: ep_data_free[g]=buf_free; buf_put = ep_data_put[g] && buf_free && (pkt_len < MAX_PKT); buf_data = ep_data[g]; buf_done = ep_data_done[g].
  - Each buf_put increments pkt_len at the edge.
  - Release happens on ep_data_done[g] or on ep_req[g] low, whichever comes first. If both occur in the same cycle, there is one release and one buf_done.
  - On release: at the edge, ep_grant=0, busy=0, state=GAP. grant_idx is kept for round-robin.
- State GAP: one mandatory dead cycle so the buffer can commit, then go to ARB. The minimum spacing between two grants is 2 cycles.
- Zero-length packet: ep_data_done[g] with pkt_len=0 and no put is legal. buf_done pulses and pkt_len stays 0.
- Put and done in the same cycle: the byte is written, then the packet commits. pkt_len counts that byte.
- Protocol errors:
  - proto_err is set if any ep_data_put or ep_data_done is asserted by a non-granted client in any state. Such strobes are ignored and never reach the buffer.
  - proto_err is set if ep_data_put[g] is asserted while pkt_len == MAX_PKT. The byte is dropped.
  - ep_data_put[g] while buf_free=0 is not an error; the byte is dropped and the client must hold it.
- Fairness: a client continuously requesting waits at most NUM_EP-1 packets.

Test Plan:
- Reset then ep_req=3'b111 -> grant to client 0 one cycle later, then 1, then 2, then 0; each grant follows done plus the GAP cycle; grant_idx sequence 0,1,2,0.
- Client 1 granted, 5 puts of 0x11..0x15 with buf_free=1, then done -> buf_data 0x11..0x15 on 5 buf_put cycles, buf_done one pulse, pkt_len=5, then ep_grant=0 and busy=0.
- MAX_PKT=32, granted client puts 34 bytes -> exactly 32 buf_put, pkt_len=32, proto_err=1 on the 33rd put.
- Client 2 (not granted) pulses ep_data_put and ep_data_done while client 0 is granted -> buf_put and buf_done unaffected, proto_err=1, client 0 grant held.
- Granted client 0 drops ep_req after 3 bytes with no done -> release at the next edge, no buf_done, the next requester is granted after the GAP cycle.
- reset_n pulled low mid-packet asynchronously (between edges) -> ep_grant=0 and busy=0 immediately; after release, a fresh ep_req from client 2 only is granted to client 2 with pkt_len=0.

Source files
------------

// File: rtl/usb_in_ep_arbiter.sv
// Round-robin arbiter sharing one USB IN packet buffer between NUM_EP endpoint clients.
// A grant is held for a whole packet; out-of-turn strobes and overlong packets set proto_err.
module usb_in_ep_arbiter #(
  parameter int unsigned NUM_EP  = 3,
  parameter int unsigned MAX_PKT = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EP-1:0]     ep_req,
  output logic [NUM_EP-1:0]     ep_grant,
  output logic [NUM_EP-1:0]     ep_data_free,
  input  logic [NUM_EP-1:0]     ep_data_put,
  input  logic [8*NUM_EP-1:0]   ep_data,
  input  logic [NUM_EP-1:0]     ep_data_done,
  input  logic                  buf_free,
  output logic                  buf_put,
  output logic [7:0]            buf_data,
  output logic                  buf_done,
  output logic [2:0]            grant_idx,
  output logic                  busy,
  output logic [6:0]            pkt_len,
  output logic                  proto_err
);

  localparam logic [6:0] MaxLen  = 7'(MAX_PKT);
  localparam logic [2:0] LastIdx = 3'(NUM_EP - 1);

  // StArb is also the reset (idle) state: it arbitrates every cycle until a request appears.
  typedef enum logic [1:0] {StArb, StHold, StGap} state_e;

  state_e            r_state;
  logic [NUM_EP-1:0] r_grant;
  logic [2:0]        r_grant_idx;
  logic              r_busy;
  logic [6:0]        r_pkt_len;
  logic              r_proto_err;

  logic              w_sel_valid;
  logic [2:0]        w_sel;
  logic [NUM_EP-1:0] w_sel_oh;
  logic              w_put_g;
  logic              w_done_g;
  logic              w_req_g;
  logic [7:0]        w_data;
  logic              w_release;
  logic              w_err;

  // Search from grant_idx+1 upwards with wrap; iterating downwards leaves the nearest hit.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    for (int k = NUM_EP; k >= 1; k--) begin
      int unsigned idx;
      idx = (int'(r_grant_idx) + k) % NUM_EP;
      if (ep_req[idx]) begin
        w_sel_valid = 1'b1;
        w_sel       = 3'(idx);
      end
    end
    w_sel_oh = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      w_sel_oh[i] = w_sel_valid && (w_sel == 3'(i));
    end
  end

  // r_grant is non-zero only in StHold, so masking with it routes only the owner.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (r_grant[i]) begin
        w_data = ep_data[8*i +: 8];
      end
    end
  end

  assign w_put_g   = |(ep_data_put & r_grant);
  assign w_done_g  = |(ep_data_done & r_grant);
  assign w_req_g   = |(ep_req & r_grant);
  assign w_release = w_done_g || !w_req_g;
  assign w_err     = (|((ep_data_put | ep_data_done) & ~r_grant)) ||
                     (w_put_g && (r_pkt_len == MaxLen));

  assign ep_data_free = r_grant & {NUM_EP{buf_free}};
  assign buf_put      = w_put_g && buf_free && (r_pkt_len < MaxLen);
  assign buf_data     = w_data;
  assign buf_done     = w_done_g;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StArb;
      r_grant     <= '0;
      r_grant_idx <= LastIdx;
      r_busy      <= 1'b0;
      r_pkt_len   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_err) begin
        r_proto_err <= 1'b1;
      end
      unique case (r_state)
        StArb: begin
          if (w_sel_valid) begin
            r_grant     <= w_sel_oh;
            r_grant_idx <= w_sel;
            r_busy      <= 1'b1;
            r_pkt_len   <= '0;
            r_state     <= StHold;
          end
        end
        StHold: begin
          if (buf_put) begin
            r_pkt_len <= r_pkt_len + 7'd1;
          end
          if (w_release) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= StGap;
          end
        end
        StGap: begin
          r_state <= StArb;
        end
        default: begin
          r_state <= StArb;
        end
      endcase
    end
  end

  assign ep_grant  = r_grant;
  assign grant_idx = r_grant_idx;
  assign busy      = r_busy;
  assign pkt_len   = r_pkt_len;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// Directed bench for usb_in_ep_arbiter (NUM_EP=3, MAX_PKT=32): arbitration order,
// data routing, length limit, protocol errors, request drop and asynchronous reset.
module tb_usb_in_ep_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  ep_req = '0;
  logic [2:0]  ep_grant;
  logic [2:0]  ep_data_free;
  logic [2:0]  ep_data_put = '0;
  logic [23:0] ep_data = '0;
  logic [2:0]  ep_data_done = '0;
  logic        buf_free = 1'b0;
  logic        buf_put;
  logic [7:0]  buf_data;
  logic        buf_done;
  logic [2:0]  grant_idx;
  logic        busy;
  logic [6:0]  pkt_len;
  logic        proto_err;

  int n_checks = 0;
  int n_pass   = 0;

  usb_in_ep_arbiter #(.NUM_EP(3), .MAX_PKT(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ep_req       (ep_req),
    .ep_grant     (ep_grant),
    .ep_data_free (ep_data_free),
    .ep_data_put  (ep_data_put),
    .ep_data      (ep_data),
    .ep_data_done (ep_data_done),
    .buf_free     (buf_free),
    .buf_put      (buf_put),
    .buf_data     (buf_data),
    .buf_done     (buf_done),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .pkt_len      (pkt_len),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  // Inputs change and registered outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    ep_req       = '0;
    ep_data_put  = '0;
    ep_data_done = '0;
    ep_data      = '0;
    buf_free     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ep_grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", ep_grant);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (grant_idx !== 3'd2) $display("FAIL reset_idx: got %0d want 2", grant_idx);
    else n_pass++;
    n_checks++;
    if (pkt_len !== 7'd0 || proto_err !== 1'b0)
      $display("FAIL reset_len_err: got len %0d err %b want 0 0", pkt_len, proto_err);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_idx;
    logic [2:0] exp_oh;
    do_reset();
    ep_req = 3'b111;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_idx = 3'(i % 3);
      exp_oh  = 3'b001 << exp_idx;
      n_checks++;
      if (ep_grant !== exp_oh || grant_idx !== exp_idx || busy !== 1'b1)
        $display("FAIL rr_grant%0d: got grant %b idx %0d busy %b want %b %0d 1",
                 i, ep_grant, grant_idx, busy, exp_oh, exp_idx);
      else n_pass++;
      ep_data_done = exp_oh;
      #1;
      n_checks++;
      if (buf_done !== 1'b1) $display("FAIL rr_done%0d: got %b want 1", i, buf_done);
      else n_pass++;
      tick();
      ep_data_done = '0;
      n_checks++;
      if (ep_grant !== 3'b000 || busy !== 1'b0)
        $display("FAIL rr_release%0d: got grant %b busy %b want 000 0", i, ep_grant, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (ep_grant !== 3'b000) $display("FAIL rr_gap%0d: got %b want 000", i, ep_grant);
      else n_pass++;
      tick();
    end
    ep_req = '0;
    tick();
    tick();
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL rr_err: got %b want 0", proto_err);
    else n_pass++;
  endtask

  task automatic test_packet();
    do_reset();
    ep_req = 3'b010;
    tick();
    n_checks++;
    if (ep_grant !== 3'b010 || grant_idx !== 3'd1)
      $display("FAIL pkt_grant: got %b idx %0d want 010 1", ep_grant, grant_idx);
    else n_pass++;
    // Put with the buffer full is dropped without error.
    ep_data_put    = 3'b010;
    ep_data[15:8]  = 8'h11;
    buf_free       = 1'b0;
    #1;
    n_checks++;
    if (buf_put !== 1'b0 || ep_data_free !== 3'b000)
      $display("FAIL pkt_full: got put %b free %b want 0 000", buf_put, ep_data_free);
    else n_pass++;
    tick();
    buf_free = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ep_data[15:8] = 8'h11 + 8'(k);
      #1;
      n_checks++;
      if (buf_put !== 1'b1 || buf_data !== 8'h11 + 8'(k) || ep_data_free !== 3'b010)
        $display("FAIL pkt_byte%0d: got put %b data %h free %b want 1 %h 010",
                 k, buf_put, buf_data, ep_data_free, 8'h11 + 8'(k));
      else n_pass++;
      tick();
    end
    ep_data_put  = '0;
    ep_data_done = 3'b010;
    #1;
    n_checks++;
    if (buf_done !== 1'b1 || buf_put !== 1'b0)
      $display("FAIL pkt_done: got done %b put %b want 1 0", buf_done, buf_put);
    else n_pass++;
    tick();
    ep_data_done = '0;
    n_checks++;
    if (pkt_len !== 7'd5 || ep_grant !== 3'b000 || busy !== 1'b0 || proto_err !== 1'b0)
      $display("FAIL pkt_end: got len %0d grant %b busy %b err %b want 5 000 0 0",
               pkt_len, ep_grant, busy, proto_err);
    else n_pass++;
    ep_req = '0;
  endtask

  task automatic test_max_pkt();
    int puts;
    puts = 0;
    do_reset();
    ep_req = 3'b001;
    tick();
    buf_free    = 1'b1;
    ep_data_put = 3'b001;
    for (int k = 0; k < 34; k++) begin
      ep_data[7:0] = 8'(k);
      #1;
      if (buf_put === 1'b1) puts++;
      tick();
      if (k == 31) begin
        n_checks++;
        if (proto_err !== 1'b0) $display("FAIL max_early_err: got %b want 0", proto_err);
        else n_pass++;
      end
      if (k == 32) begin
        n_checks++;
        if (proto_err !== 1'b1) $display("FAIL max_err: got %b want 1", proto_err);
        else n_pass++;
      end
    end
    ep_data_put = '0;
    n_checks++;
    if (puts != 32) $display("FAIL max_puts: got %0d want 32", puts);
    else n_pass++;
    n_checks++;
    if (pkt_len !== 7'd32) $display("FAIL max_len: got %0d want 32", pkt_len);
    else n_pass++;
    ep_req = '0;
    tick();
  endtask

  task automatic test_foreign_strobe();
    do_reset();
    ep_req = 3'b001;
    tick();
    buf_free      = 1'b1;
    ep_data[7:0]  = 8'hA5;
    ep_data[23:16] = 8'h5A;
    ep_data_put   = 3'b101;
    ep_data_done  = 3'b100;
    #1;
    n_checks++;
    if (buf_put !== 1'b1 || buf_data !== 8'hA5 || buf_done !== 1'b0)
      $display("FAIL foreign_route: got put %b data %h done %b want 1 a5 0",
               buf_put, buf_data, buf_done);
    else n_pass++;
    tick();
    ep_data_put  = '0;
    ep_data_done = '0;
    n_checks++;
    if (proto_err !== 1'b1 || ep_grant !== 3'b001 || busy !== 1'b1 || pkt_len !== 7'd1)
      $display("FAIL foreign_state: got err %b grant %b busy %b len %0d want 1 001 1 1",
               proto_err, ep_grant, busy, pkt_len);
    else n_pass++;
    ep_req = '0;
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    ep_req = 3'b011;
    tick();
    buf_free    = 1'b1;
    ep_data_put = 3'b001;
    for (int k = 0; k < 3; k++) tick();
    ep_data_put = '0;
    ep_req      = 3'b010;
    #1;
    n_checks++;
    if (buf_done !== 1'b0) $display("FAIL drop_nodone: got %b want 0", buf_done);
    else n_pass++;
    tick();
    n_checks++;
    if (ep_grant !== 3'b000 || busy !== 1'b0 || pkt_len !== 7'd3)
      $display("FAIL drop_release: got grant %b busy %b len %0d want 000 0 3",
               ep_grant, busy, pkt_len);
    else n_pass++;
    tick();
    n_checks++;
    if (ep_grant !== 3'b000) $display("FAIL drop_gap: got %b want 000", ep_grant);
    else n_pass++;
    tick();
    n_checks++;
    if (ep_grant !== 3'b010 || grant_idx !== 3'd1 || proto_err !== 1'b0)
      $display("FAIL drop_next: got grant %b idx %0d err %b want 010 1 0",
               ep_grant, grant_idx, proto_err);
    else n_pass++;
    ep_req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    ep_req = 3'b001;
    tick();
    buf_free    = 1'b1;
    ep_data_put = 3'b001;
    tick();
    tick();
    ep_data_put = '0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ep_grant !== 3'b000 || busy !== 1'b0 || pkt_len !== 7'd0)
      $display("FAIL async_drop: got grant %b busy %b len %0d want 000 0 0",
               ep_grant, busy, pkt_len);
    else n_pass++;
    ep_req = 3'b100;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (ep_grant !== 3'b100 || grant_idx !== 3'd2 || pkt_len !== 7'd0)
      $display("FAIL async_regrant: got grant %b idx %0d len %0d want 100 2 0",
               ep_grant, grant_idx, pkt_len);
    else n_pass++;
    ep_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet();
    test_max_pkt();
    test_foreign_strobe();
    test_req_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
